// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states and constants for the I2C target.
package i2c_pkg;
  localparam int REG_DEPTH = 8;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: N-flop synchroniser (resets to 1, the idle bus level) with rise/fall pulses.
module i2c_sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [N-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end
  assign q_o = sync_q[N-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target with an 8-entry register file and auto-incrementing pointer.
// Read support (addr+R) is compiled in only when I2C_TARGET_READ_EN is defined.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h2A,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [2:0] maddr,
  output logic [7:0] sdata,
  output logic       wr_pulse,
  output logic [2:0] wr_addr,
  output logic       busy
);
  state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, byte_w;
  logic [2:0] cnt_q, cnt_d, ptr_q, ptr_d, ptr_nx, wr_addr_q, wr_addr_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_pulse_q, wr_pulse_d, we;
  logic [7:0] regs_q [REG_DEPTH];
  logic scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall, start, stop, last;
`ifdef I2C_TARGET_READ_EN
  logic rw_q, rw_d, ack_bit_q, ack_bit_d;
`endif

  i2c_sync_edge #(.N(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .d_i(scl_i), .q_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  i2c_sync_edge #(.N(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .d_i(sda_i), .q_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start = sda_fall & scl_s;
  assign stop = sda_rise & scl_s;
  assign byte_w = {shift_q[6:0], sda_s};
  assign last = scl_rise && cnt_q == 3'd7;
  assign ptr_nx = ptr_q + 3'd1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    wr_addr_d = wr_addr_q;
    sda_oe_d = sda_oe_q;
    busy_d = busy_q;
    wr_pulse_d = 1'b0;
    we = 1'b0;
`ifdef I2C_TARGET_READ_EN
    rw_d = rw_q;
    ack_bit_d = ack_bit_q;
`endif
    if (stop) begin
      state_d = IDLE;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
      cnt_d = 3'd0;
      shift_d = 8'h00;
    end else if (start) begin
      state_d = ADDR;
      sda_oe_d = 1'b0;
      cnt_d = 3'd0;
      shift_d = 8'h00;
    end else begin
      if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
        shift_d = byte_w;
        cnt_d = cnt_q + 3'd1;
      end
      case (state_q)
        ADDR: if (last) begin
          busy_d = byte_w[7:1] == SLV_ADDR;
          state_d = (byte_w[7:1] == SLV_ADDR) ? ADDR_ACK : IGNORE;
`ifdef I2C_TARGET_READ_EN
          rw_d = byte_w[0];
`else
          if (byte_w[0]) begin
            busy_d = 1'b0;
            state_d = IGNORE;
          end
`endif
        end
        PTR: if (last) begin
          ptr_d = byte_w[2:0];
          state_d = PTR_ACK;
        end
        WDATA: if (last) begin
          we = 1'b1;
          wr_pulse_d = 1'b1;
          wr_addr_d = ptr_q;
          ptr_d = ptr_nx;
          state_d = WDATA_ACK;
        end
        // First SCL fall starts driving the ACK, the second one releases it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          sda_oe_d = !sda_oe_q;
          if (sda_oe_q) state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
`ifdef I2C_TARGET_READ_EN
          if (sda_oe_q && state_q == ADDR_ACK && rw_q) begin
            state_d = RDATA;
            shift_d = regs_q[ptr_q];
            sda_oe_d = !regs_q[ptr_q][7];
          end
`endif
        end
`ifdef I2C_TARGET_READ_EN
        RDATA: begin
          if (scl_fall) begin
            shift_d = {shift_q[6:0], 1'b0};
            sda_oe_d = !shift_q[6];
          end
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = RDATA_ACK;
          end
        end
        // cnt_q marks whether the master's ACK bit has been sampled yet.
        RDATA_ACK: begin
          if (scl_rise) begin
            cnt_d = 3'd1;
            ack_bit_d = sda_s;
          end
          if (scl_fall && cnt_q == 3'd0) sda_oe_d = 1'b0;
          else if (scl_fall && ack_bit_q == NACK) begin
            state_d = IGNORE;
            busy_d = 1'b0;
            cnt_d = 3'd0;
          end else if (scl_fall) begin
            ptr_d = ptr_nx;
            shift_d = regs_q[ptr_nx];
            sda_oe_d = !regs_q[ptr_nx][7];
            cnt_d = 3'd0;
            state_d = RDATA;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      cnt_q <= 3'd0;
      ptr_q <= 3'd0;
      wr_addr_q <= 3'd0;
      sda_oe_q <= 1'b0;
      busy_q <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      wr_addr_q <= wr_addr_d;
      sda_oe_q <= sda_oe_d;
      busy_q <= busy_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

`ifdef I2C_TARGET_READ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q <= 1'b0;
      ack_bit_q <= ACK;
    end else begin
      rw_q <= rw_d;
      ack_bit_q <= ack_bit_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '{default: 8'h00};
    else if (we) regs_q[ptr_q] <= byte_w;
  end

  assign sdata = regs_q[maddr];
  assign sda_oe = sda_oe_q;
  assign busy = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr = wr_addr_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master transactions against i2c_target with hand-computed expectations.
module tb_i2c_target;
  localparam int Q = 6;
  logic clk = 1'b0, rst = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, wr_pulse, busy, sda_line;
  logic [2:0] maddr = 3'd0, wr_addr;
  logic [7:0] sdata;
  int total = 0, bad = 0, wp_cnt = 0;
  logic [2:0] wp_addr [64];
  logic [7:0] exp_regs [8];

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .maddr(maddr), .sdata(sdata), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .busy(busy)
  );

  always @(negedge clk) if (wr_pulse) begin
    if (wp_cnt < 64) wp_addr[wp_cnt] = wr_addr;
    wp_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    r = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic start_c;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic stop_c;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(~mack, r);
  endtask

  task automatic test_reset;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL reset_wr_pulse got=%b exp=0", wr_pulse); end
    total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    for (int i = 0; i < 8; i++) begin
      maddr = i[2:0]; #1;
      total++; if (sdata !== 8'h00) begin bad++; $display("FAIL reset_reg%0d got=%h exp=00", i, sdata); end
    end
    tick(2); rst = 1'b1; tick(4);
  endtask

  task automatic test_write;
    logic [3:0] a;
    int w0 = wp_cnt;
    start_c;
    wr_byte(8'h54, a[3]); wr_byte(8'h03, a[2]); wr_byte(8'hA5, a[1]); wr_byte(8'h5C, a[0]);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy); end
    stop_c; tick(4);
    total++; if (a !== 4'hF) begin bad++; $display("FAIL write_acks got=%b exp=1111", a); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
    total++; if (wp_cnt - w0 !== 2) begin bad++; $display("FAIL write_pulses got=%0d exp=2", wp_cnt - w0); end
    total++; if (wp_addr[w0] !== 3'd3 || wp_addr[w0+1] !== 3'd4) begin
      bad++; $display("FAIL write_wr_addr got=%0d,%0d exp=3,4", wp_addr[w0], wp_addr[w0+1]);
    end
    exp_regs[3] = 8'hA5; exp_regs[4] = 8'h5C;
    for (int i = 0; i < 8; i++) begin
      maddr = i[2:0]; #1;
      total++; if (sdata !== exp_regs[i]) begin bad++; $display("FAIL write_reg%0d got=%h exp=%h", i, sdata, exp_regs[i]); end
    end
  endtask

  task automatic test_mismatch;
    logic [2:0] a;
    int w0 = wp_cnt;
    start_c;
    wr_byte(8'h56, a[2]);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mismatch_busy got=%b exp=0", busy); end
    wr_byte(8'h00, a[1]); wr_byte(8'hFF, a[0]);
    stop_c; tick(4);
    total++; if (a !== 3'b000) begin bad++; $display("FAIL mismatch_acks got=%b exp=000", a); end
    total++; if (wp_cnt !== w0) begin bad++; $display("FAIL mismatch_pulses got=%0d exp=%0d", wp_cnt, w0); end
    for (int i = 0; i < 8; i++) begin
      maddr = i[2:0]; #1;
      total++; if (sdata !== exp_regs[i]) begin bad++; $display("FAIL mismatch_reg%0d got=%h exp=%h", i, sdata, exp_regs[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] a;
    int w0 = wp_cnt;
    start_c;
    wr_byte(8'h54, a[3]); wr_byte(8'h07, a[2]); wr_byte(8'h11, a[1]); wr_byte(8'h22, a[0]);
    stop_c; tick(4);
    total++; if (a !== 4'hF) begin bad++; $display("FAIL wrap_acks got=%b exp=1111", a); end
    total++; if (wp_cnt - w0 !== 2 || wp_addr[w0] !== 3'd7 || wp_addr[w0+1] !== 3'd0) begin
      bad++; $display("FAIL wrap_wr_addr got=%0d:%0d,%0d exp=2:7,0", wp_cnt - w0, wp_addr[w0], wp_addr[w0+1]);
    end
    exp_regs[7] = 8'h11; exp_regs[0] = 8'h22;
    for (int i = 0; i < 8; i++) begin
      maddr = i[2:0]; #1;
      total++; if (sdata !== exp_regs[i]) begin bad++; $display("FAIL wrap_reg%0d got=%h exp=%h", i, sdata, exp_regs[i]); end
    end
  endtask

  task automatic test_partial_stop;
    logic [1:0] a;
    logic r;
    int w0 = wp_cnt;
    start_c;
    wr_byte(8'h54, a[1]); wr_byte(8'h01, a[0]);
    for (int i = 0; i < 5; i++) bit_io(1'b1, r);
    stop_c; tick(4);
    total++; if (a !== 2'b11) begin bad++; $display("FAIL partial_acks got=%b exp=11", a); end
    total++; if (wp_cnt !== w0) begin bad++; $display("FAIL partial_pulses got=%0d exp=%0d", wp_cnt, w0); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL partial_sda_oe got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL partial_busy got=%b exp=0", busy); end
    maddr = 3'd1; #1;
    total++; if (sdata !== exp_regs[1]) begin bad++; $display("FAIL partial_reg1 got=%h exp=%h", sdata, exp_regs[1]); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] a;
    int w0 = wp_cnt;
    start_c;
    wr_byte(8'h54, a[5]); wr_byte(8'h02, a[4]); wr_byte(8'h77, a[3]);
    start_c;
    wr_byte(8'h54, a[2]); wr_byte(8'h06, a[1]); wr_byte(8'h66, a[0]);
    stop_c; tick(4);
    total++; if (a !== 6'h3F) begin bad++; $display("FAIL b2b_acks got=%b exp=111111", a); end
    total++; if (wp_cnt - w0 !== 2 || wp_addr[w0] !== 3'd2 || wp_addr[w0+1] !== 3'd6) begin
      bad++; $display("FAIL b2b_wr_addr got=%0d:%0d,%0d exp=2:2,6", wp_cnt - w0, wp_addr[w0], wp_addr[w0+1]);
    end
    exp_regs[2] = 8'h77; exp_regs[6] = 8'h66;
    for (int i = 0; i < 8; i++) begin
      maddr = i[2:0]; #1;
      total++; if (sdata !== exp_regs[i]) begin bad++; $display("FAIL b2b_reg%0d got=%h exp=%h", i, sdata, exp_regs[i]); end
    end
  endtask

`ifdef I2C_TARGET_READ_EN
  task automatic test_read;
    logic [2:0] a;
    logic [7:0] d0, d1;
    start_c;
    wr_byte(8'h54, a[2]); wr_byte(8'h03, a[1]);
    start_c;
    wr_byte(8'h55, a[0]);
    rd_byte(1'b1, d0); rd_byte(1'b0, d1);
    tick(4);
    total++; if (a !== 3'b111) begin bad++; $display("FAIL read_acks got=%b exp=111", a); end
    total++; if (d0 !== 8'hA5) begin bad++; $display("FAIL read_byte0 got=%h exp=a5", d0); end
    total++; if (d1 !== 8'h5C) begin bad++; $display("FAIL read_byte1 got=%h exp=5c", d1); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL read_release got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy got=%b exp=0", busy); end
    stop_c; tick(4);
  endtask
`else
  task automatic test_read_nack;
    logic a;
    start_c;
    wr_byte(8'h55, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL read_nack_ack got=%b exp=0", a); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_nack_busy got=%b exp=0", busy); end
    stop_c; tick(4);
  endtask
`endif

  task automatic test_reset_ack;
    logic [2:0] a;
    logic r;
    int n = 0;
    int w0;
    start_c;
    for (int i = 7; i >= 0; i--) bit_io(i[0] ^ 1'b0 ? 8'h54 >> i & 1 : 8'h54 >> i & 1, r);
    while (sda_oe !== 1'b1 && n < 20) begin tick(1); n++; end
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rstack_drive got=%b exp=1", sda_oe); end
    @(posedge clk); #2; rst = 1'b0; #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rstack_sda_oe got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstack_busy got=%b exp=0", busy); end
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    rst = 1'b1; tick(Q);
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    w0 = wp_cnt;
    start_c;
    wr_byte(8'h54, a[2]); wr_byte(8'h05, a[1]); wr_byte(8'h3C, a[0]);
    stop_c; tick(4);
    total++; if (a !== 3'b111) begin bad++; $display("FAIL rstack_acks got=%b exp=111", a); end
    total++; if (wp_cnt - w0 !== 1 || wp_addr[w0] !== 3'd5) begin
      bad++; $display("FAIL rstack_wr_addr got=%0d:%0d exp=1:5", wp_cnt - w0, wp_addr[w0]);
    end
    exp_regs[5] = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      maddr = i[2:0]; #1;
      total++; if (sdata !== exp_regs[i]) begin bad++; $display("FAIL rstack_reg%0d got=%h exp=%h", i, sdata, exp_regs[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    test_reset;
    test_write;
    test_mismatch;
    test_wrap;
    test_partial_stop;
    test_back_to_back;
`ifdef I2C_TARGET_READ_EN
    test_read;
`else
    test_read_nack;
`endif
    test_reset_ack;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
